// File: rtl/count_arbiter_if.sv
// Link between count_arbiter (master) and the shared count_fsm (slave).
interface count_arbiter_if #(
    parameter int TIMER_W = 16,
    parameter int CNT_W   = 8
);
    logic               start;
    logic               flag;
    logic [TIMER_W-1:0] wait_timer;
    logic               busy;
    logic [CNT_W-1:0]   count_value;

    modport master (output start, output flag, output wait_timer,
                    input  busy,  input  count_value);
    modport slave  (input  start, input  flag, input  wait_timer,
                    output busy,  output count_value);
endinterface

// File: rtl/count_arbiter.sv
// Round-robin arbiter sharing one count_fsm among N_REQ requesters.
// All outputs are registered and reflect the state entered on the same edge.
module count_arbiter #(
    parameter int N_REQ    = 4,
    parameter int TIMER_W  = 16,
    parameter int CNT_W    = 8,
    parameter int START_TO = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*TIMER_W-1:0] req_timer,
    input  logic [N_REQ-1:0]         req_flag,
    output logic [N_REQ-1:0]         done,
    output logic [CNT_W-1:0]         result,
    output logic                     result_vld,
    output logic                     err_timeout,
    count_arbiter_if.master          fsm
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TO_W  = (START_TO > 0) ? $clog2(START_TO + 1) : 1;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, RUN, DONE} state_t;

    state_t             state, state_n;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_n, winner, winner_n, grant_idx;
    logic               grant_found;
    int                 rr_idx;
    logic [TIMER_W-1:0] lat_timer, lat_timer_n;
    logic               lat_flag, lat_flag_n;
    logic [TO_W-1:0]    tcnt, tcnt_n;

    logic               start_n, flag_n, result_vld_n, err_n;
    logic [TIMER_W-1:0] wait_timer_n;
    logic [N_REQ-1:0]   done_n;
    logic [CNT_W-1:0]   result_n;

    // First active requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_idx      = 0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            rr_idx = (int'(rr_ptr) + int'(off)) % N_REQ;
            if (!grant_found && req[rr_idx]) begin
                grant_found = 1'b1;
                grant_idx   = rr_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_n      = state;
        rr_ptr_n     = rr_ptr;
        winner_n     = winner;
        lat_timer_n  = lat_timer;
        lat_flag_n   = lat_flag;
        tcnt_n       = tcnt;
        start_n      = 1'b0;
        done_n       = '0;
        result_n     = '0;
        result_vld_n = 1'b0;
        err_n        = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    winner_n    = grant_idx;
                    lat_timer_n = req_timer[int'(grant_idx)*TIMER_W +: TIMER_W];
                    lat_flag_n  = req_flag[grant_idx];
                    rr_ptr_n    = PTR_W'((int'(grant_idx) + 1) % N_REQ);
                    state_n     = LAUNCH;
                end
            end
            LAUNCH: begin
                start_n = 1'b1;
                tcnt_n  = '0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (fsm.busy) begin
                    state_n = RUN;
                end else if (tcnt == TO_W'(START_TO)) begin
                    state_n        = DONE;
                    done_n[winner] = 1'b1;
                    result_vld_n   = 1'b1;
                    err_n          = 1'b1;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            RUN: begin
                if (!fsm.busy) begin
                    state_n        = DONE;
                    done_n[winner] = 1'b1;
                    result_vld_n   = 1'b1;
                    result_n       = fsm.count_value;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Launch values are driven only while a run is in flight.
        flag_n       = 1'b0;
        wait_timer_n = '0;
        if (state_n == WAIT_BUSY || state_n == RUN) begin
            flag_n       = lat_flag;
            wait_timer_n = lat_timer;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            winner         <= '0;
            lat_timer      <= '0;
            lat_flag       <= 1'b0;
            tcnt           <= '0;
            fsm.start      <= 1'b0;
            fsm.flag       <= 1'b0;
            fsm.wait_timer <= '0;
            done           <= '0;
            result         <= '0;
            result_vld     <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            state          <= state_n;
            rr_ptr         <= rr_ptr_n;
            winner         <= winner_n;
            lat_timer      <= lat_timer_n;
            lat_flag       <= lat_flag_n;
            tcnt           <= tcnt_n;
            fsm.start      <= start_n;
            fsm.flag       <= flag_n;
            fsm.wait_timer <= wait_timer_n;
            done           <= done_n;
            result         <= result_n;
            result_vld     <= result_vld_n;
            err_timeout    <= err_n;
        end
    end
endmodule

// File: tb/tb_count_arbiter.sv
// Directed and randomized checks of count_arbiter against a round-robin reference model.
module tb_count_arbiter;
    localparam int N   = 4;
    localparam int TW  = 16;
    localparam int CW  = 8;
    localparam int STO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, req_flag, done;
    logic [N*TW-1:0] req_timer;
    logic [CW-1:0]   result;
    logic            result_vld, err_timeout;

    count_arbiter_if #(.TIMER_W(TW), .CNT_W(CW)) fsm_if ();

    count_arbiter #(.N_REQ(N), .TIMER_W(TW), .CNT_W(CW), .START_TO(STO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_timer(req_timer),
        .req_flag(req_flag), .done(done), .result(result),
        .result_vld(result_vld), .err_timeout(err_timeout), .fsm(fsm_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_now  = 0;
    int model_ptr = 0;
    int last_start = 0;
    int last_done  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_now++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: first active requester at or after ptr in cyclic order.
    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        fsm_if.busy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_ptr = 0;
    endtask

    task automatic serve(input int w, input int exp_lat, input int blen,
                         input logic [CW-1:0] val, input bit to_mode, input int drop);
        int n;
        logic ef;
        logic [TW-1:0] et;
        logic [N-1:0] oh;
        ef = req_flag[w];
        et = req_timer[w*TW +: TW];
        oh = '0;
        oh[w] = 1'b1;
        n = 0;
        while (fsm_if.start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("start_seen", fsm_if.start, 1);
        if (exp_lat >= 0) check("start_latency", n, exp_lat);
        check("flag_at_start", fsm_if.flag, ef);
        check("timer_at_start", fsm_if.wait_timer, et);
        last_start = cyc_now;
        tick();
        check("start_one_cycle", fsm_if.start, 0);
        if (to_mode) begin
            for (int k = 2; k <= STO; k++) begin
                tick();
                check("to_wait_hold", {fsm_if.start, result_vld, fsm_if.flag, fsm_if.wait_timer},
                      {2'b00, ef, et});
            end
            tick();
            check("to_err", err_timeout, 1);
            check("to_result", result, 0);
        end else begin
            fsm_if.busy = 1'b1;
            fsm_if.count_value = CW'($urandom);
            if (drop >= 0) req[drop] = 1'b0;
            for (int k = 0; k < blen; k++) begin
                tick();
                check("run_hold", {fsm_if.start, result_vld, fsm_if.flag, fsm_if.wait_timer},
                      {2'b00, ef, et});
            end
            fsm_if.busy = 1'b0;
            fsm_if.count_value = val;
            tick();
            check("run_err", err_timeout, 0);
            check("run_result", result, val);
        end
        check("done_onehot", done, oh);
        check("result_vld", result_vld, 1);
        check("flag_off_in_done", {fsm_if.flag, fsm_if.wait_timer}, 0);
        last_done = cyc_now;
        model_ptr = (w + 1) % N;
        fsm_if.count_value = CW'($urandom);
        tick();
        check("done_one_cycle", {done, result_vld, err_timeout}, 0);
    endtask

    initial begin
        int w, prev_done, starts;
        rst_n = 1'b0;
        req = 4'b1111;
        req_flag = '0;
        req_timer = '0;
        fsm_if.busy = 1'b0;
        fsm_if.count_value = '0;
        tick();
        check("reset_start", fsm_if.start, 0);
        tick();
        tick();
        check("reset_outputs", {fsm_if.start, fsm_if.flag, fsm_if.wait_timer, done, result,
                                result_vld, err_timeout}, 0);
        req = '0;
        rst_n = 1'b1;
        tick();

        // Single request, busy outlasting START_TO (no RUN timeout)
        req = 4'b0010;
        req_flag = 4'b0010;
        req_timer[1*TW +: TW] = 16'd5;
        w = rr_pick(req, model_ptr);
        serve(w, 2, 10, 8'h0A, 1'b0, -1);
        req = '0;

        // Fairness with all requesters held
        do_reset();
        req = 4'b1111;
        req_flag = 4'($urandom);
        for (int i = 0; i < N; i++) req_timer[i*TW +: TW] = TW'(16'h100 + i);
        for (int r = 0; r < 5; r++) begin
            w = rr_pick(req, model_ptr);
            serve(w, 2, 1 + r, CW'(8'h20 + r), 1'b0, -1);
        end
        req = '0;

        // Timeout with busy held low, then normal service afterwards
        req = 4'b0100;
        req_flag[2] = 1'b1;
        w = rr_pick(req, model_ptr);
        serve(w, 2, 0, '0, 1'b1, -1);

        // Back-to-back requesters 0 and 3
        req = 4'b1001;
        req_timer[0*TW +: TW] = 16'hAAAA;
        req_timer[3*TW +: TW] = 16'h5555;
        req_flag = 4'b1000;
        w = rr_pick(req, model_ptr);
        serve(w, 2, 3, 8'h33, 1'b0, -1);
        prev_done = last_done;
        w = rr_pick(req, model_ptr);
        serve(w, 2, 2, 8'h44, 1'b0, -1);
        check("b2b_gap", (last_start - prev_done) >= 3, 1);
        req = '0;

        // Withdrawn request: requester 2 drops req during its run
        req = 4'b0100;
        w = rr_pick(req, model_ptr);
        serve(w, 2, 4, 8'h77, 1'b0, 2);
        starts = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (fsm_if.start === 1'b1) starts++;
        end
        check("withdrawn_no_restart", starts, 0);

        // Reset in the middle of a run
        req = 4'b0010;
        req_flag = 4'b0010;
        req_timer[1*TW +: TW] = 16'd7;
        tick();
        tick();
        check("mr_start", fsm_if.start, 1);
        tick();
        fsm_if.busy = 1'b1;
        tick();
        tick();
        check("mr_flag_before_reset", {fsm_if.flag, fsm_if.wait_timer}, {1'b1, 16'd7});
        rst_n = 1'b0;
        req = '0;
        #1;
        check("mr_outputs_zero", {fsm_if.start, fsm_if.flag, fsm_if.wait_timer, done, result,
                                  result_vld, err_timeout}, 0);
        fsm_if.busy = 1'b0;
        tick();
        tick();
        check("mr_no_done", {done, result_vld}, 0);
        rst_n = 1'b1;
        model_ptr = 0;
        req = 4'b1000;
        req_flag = 4'b1000;
        w = rr_pick(req, model_ptr);
        serve(w, 2, 2, 8'h5A, 1'b0, -1);
        req = '0;

        // Randomized requests against the reference model
        for (int it = 0; it < 12; it++) begin
            bit to;
            req = 4'($urandom_range(1, 15));
            req_flag = 4'($urandom);
            for (int i = 0; i < N; i++) req_timer[i*TW +: TW] = TW'($urandom);
            to = ($urandom_range(0, 4) == 0);
            w = rr_pick(req, model_ptr);
            serve(w, 2, int'($urandom_range(1, 5)), CW'($urandom), to, -1);
        end
        req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
